bcd_updown_counter_mod: RTL and testbench
=========================================

// Module: bcd_updown_counter_mod
// PURPOSE
//  Parametrised loadable BCD up/down counter that counts 0..MAX_VALUE, wrapping in both directions.
//  Used for clock/stopwatch/timer fields, e.g. seconds, minutes (59), hours (23) and day-of-month.
//  Generalises the fixed mod-60 loadable counter with:
//   - any digit count and modulus
//   - count direction
//   - synchronous clear
//   - load validation
//   - carry/borrow pulses for cascading fields
// PARAMETERS
//  DIGITS     2   number of BCD digits (1..4); value bus is 4*DIGITS bits
//  MAX_VALUE  59  terminal count (decimal); must satisfy 1 <= MAX_VALUE <= 10**DIGITS-1
// PORTS
//  clk          in   1          system clock, rising edge
//  reset_p      in   1          asynchronous, active-high reset
//  clk_time     in   1          count tick, 1-cycle strobe in clk domain
//  up_down      in   1          1 = count up, 0 = count down; sampled with clk_time
//  clear        in   1          synchronous clear to 0
//  load_enable  in   1          synchronous load of set_value
//  set_value    in   4*DIGITS   BCD load value; digit i at [4i+3:4i]
//  bcd_out      out  4*DIGITS   current count, BCD; digit 0 = ones
//  carry_out    out  1          1-cycle pulse: up-count wrapped MAX_VALUE -> 0
//  borrow_out   out  1          1-cycle pulse: down-count wrapped 0 -> MAX_VALUE
//  load_err     out  1          1-cycle pulse: load_enable with invalid set_value
// BEHAVIOUR
//  - Reset: reset_p=1 asynchronously forces bcd_out=0, carry_out=0, borrow_out=0, load_err=0.
//  - All outputs are registered and update on the posedge where the action is sampled.
//    No extra latency; pulses coincide with the new bcd_out value.
//  - Per-edge priority: reset_p > clear > load_enable > clk_time > hold.
//  - clear=1: bcd_out<=0; ticks and loads that edge are dropped; no pulses.
//  - load_enable=1, set_value valid: bcd_out<=set_value; tick that edge dropped; no carry/borrow.
//    Valid means every digit <= 9 AND decimal value <= MAX_VALUE.
//  - load_enable=1, set_value invalid: bcd_out unchanged, load_err=1 for one cycle, tick dropped.
//  - clk_time=1, up_down=1:
//    - bcd_out==MAX_VALUE -> bcd_out<=0 and carry_out=1.
//    - Otherwise increment with decimal ripple: digit 9 -> 0, +1 to the next digit.
//  - clk_time=1, up_down=0:
//    - bcd_out==0 -> bcd_out<=MAX_VALUE and borrow_out=1.
//    - Otherwise decrement with decimal borrow: digit 0 -> 9, -1 to the next digit.
//  - Terminal compare is on the BCD representation of MAX_VALUE, precomputed at elaboration.
//    No binary<->BCD conversion in the datapath.
//  - carry_out, borrow_out and load_err return to 0 on the next edge unless re-triggered.
//    Back-to-back wrapping ticks give back-to-back pulses.
//  - clk_time=0 and no clear/load: hold value; all pulses 0.
//  - Digit state is never permitted > 9 or value > MAX_VALUE. Only valid loads write the register,
//    so this invariant holds after reset.
//  - Cascading: a field's carry_out/borrow_out drives the next field's clk_time, one clk later.
//    up_down is shared between fields.
//  - Reset asserted mid-count or mid-pulse: immediate return to the reset values.
//    Counting resumes on the first clk_time after reset_p deasserts.
//  - Illegal parameters (MAX_VALUE >= 10**DIGITS, or DIGITS outside 1..4) are an elaboration error.
// TESTING
//  1. Default params, reset then 60 up ticks:
//     - 00,01..59 then 00.
//     - carry_out=1 only on the edge producing 00 after 59.
//  2. Down count from 00, one tick:
//     - bcd_out=59 and borrow_out=1.
//     - Next tick: 58, borrow_out=0.
//  3. Loads:
//     - set_value=8'h45 -> bcd_out=45, load_err=0.
//     - set_value=8'h60 or 8'h3A -> bcd_out stays 45, load_err=1 for 1 cycle.
//  4. Simultaneous events:
//     - clear+load+tick with bcd_out=59 -> 00, no carry.
//     - load 8'h59 + up tick -> 59, no carry.
//  5. DIGITS=2, MAX_VALUE=23: up from 19 -> 20 (decimal ripple), 23 -> 00 with carry.
//     DIGITS=3, MAX_VALUE=999: 099 -> 100.
//  6. Assert reset_p asynchronously mid-cycle while bcd_out=37 and carry_out=1:
//     - Outputs go 0 immediately.
//     - First tick after release gives 01.

Source files
------------

// File: rtl/bcd_updown_counter_mod.sv
// Loadable BCD up/down counter with wrap at 0 and MAX_VALUE, carry/borrow pulses
// for cascading time fields, and load validation against the terminal count.
module bcd_updown_counter_mod #(
    parameter int DIGITS    = 2,
    parameter int MAX_VALUE = 59
) (
    input  logic                  clk,
    input  logic                  reset_p,
    input  logic                  clk_time,
    input  logic                  up_down,
    input  logic                  clear,
    input  logic                  load_enable,
    input  logic [4*DIGITS-1:0]   set_value,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  carry_out,
    output logic                  borrow_out,
    output logic                  load_err
);

    localparam int W = 4 * DIGITS;

    if (DIGITS < 1 || DIGITS > 4) begin : g_bad_digits
        $error("bcd_updown_counter_mod: DIGITS must be 1..4");
    end
    if (MAX_VALUE < 1 || MAX_VALUE > (10 ** DIGITS) - 1) begin : g_bad_max
        $error("bcd_updown_counter_mod: MAX_VALUE must be 1..10**DIGITS-1");
    end

    function automatic logic [W-1:0] to_bcd(input int value);
        logic [W-1:0] r;
        int           t;
        r = '0;
        t = value;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic digits_ok(input logic [W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (c) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         b;
        r = v;
        b = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (b) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return r;
    endfunction

    localparam logic [W-1:0] MAX_BCD = to_bcd(MAX_VALUE);

    logic [W-1:0] cnt_q, cnt_d;
    logic         carry_q, carry_d;
    logic         borrow_q, borrow_d;
    logic         err_q, err_d;
    logic         load_valid;

    // With all digits <= 9, BCD ordering equals decimal ordering, so a plain
    // unsigned compare against MAX_BCD is enough.
    assign load_valid = digits_ok(set_value) && (set_value <= MAX_BCD);

    always_comb begin
        cnt_d    = cnt_q;
        carry_d  = 1'b0;
        borrow_d = 1'b0;
        err_d    = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (load_enable) begin
            if (load_valid) cnt_d = set_value;
            else            err_d = 1'b1;
        end else if (clk_time) begin
            if (up_down) begin
                if (cnt_q == MAX_BCD) begin
                    cnt_d   = '0;
                    carry_d = 1'b1;
                end else begin
                    cnt_d = bcd_inc(cnt_q);
                end
            end else begin
                if (cnt_q == '0) begin
                    cnt_d    = MAX_BCD;
                    borrow_d = 1'b1;
                end else begin
                    cnt_d = bcd_dec(cnt_q);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
            err_q    <= err_d;
        end
    end

    assign bcd_out    = cnt_q;
    assign carry_out  = carry_q;
    assign borrow_out = borrow_q;
    assign load_err   = err_q;

endmodule

// File: tb/tb_bcd_updown_counter_mod.sv
// Bench for bcd_updown_counter_mod: three instances (2-digit mod 60, 2-digit mod 24,
// 3-digit mod 1000) on shared stimulus, checked against an integer reference model.
module tb_bcd_updown_counter_mod;

    logic        clk = 1'b0;
    logic        reset_p;
    logic        clk_time, up_down, clear, load_enable;
    logic [11:0] sv12;

    logic [7:0]  bcd0, bcd1;
    logic [11:0] bcd2;
    logic        got_c [3];
    logic        got_b [3];
    logic        got_e [3];
    logic [11:0] got_val [3];

    assign got_val[0] = {4'h0, bcd0};
    assign got_val[1] = {4'h0, bcd1};
    assign got_val[2] = bcd2;

    always #5 clk = ~clk;

    bcd_updown_counter_mod #(.DIGITS(2), .MAX_VALUE(59)) u_d0 (
        .clk(clk), .reset_p(reset_p), .clk_time(clk_time), .up_down(up_down),
        .clear(clear), .load_enable(load_enable), .set_value(sv12[7:0]),
        .bcd_out(bcd0), .carry_out(got_c[0]), .borrow_out(got_b[0]), .load_err(got_e[0]));

    bcd_updown_counter_mod #(.DIGITS(2), .MAX_VALUE(23)) u_d1 (
        .clk(clk), .reset_p(reset_p), .clk_time(clk_time), .up_down(up_down),
        .clear(clear), .load_enable(load_enable), .set_value(sv12[7:0]),
        .bcd_out(bcd1), .carry_out(got_c[1]), .borrow_out(got_b[1]), .load_err(got_e[1]));

    bcd_updown_counter_mod #(.DIGITS(3), .MAX_VALUE(999)) u_d2 (
        .clk(clk), .reset_p(reset_p), .clk_time(clk_time), .up_down(up_down),
        .clear(clear), .load_enable(load_enable), .set_value(sv12),
        .bcd_out(bcd2), .carry_out(got_c[2]), .borrow_out(got_b[2]), .load_err(got_e[2]));

    typedef struct {
        logic       clr;
        logic       ld;
        logic       tk;
        logic       up;
        logic [11:0] sv;
    } stim_t;

    typedef struct {
        logic [11:0] val;
        logic        c;
        logic        b;
        logic        e;
    } exp_t;

    exp_t sb [$];
    int   mval [3];
    int   errors = 0;
    int   checks = 0;

    function automatic int maxv(input int d);
        case (d)
            0:       return 59;
            1:       return 23;
            default: return 999;
        endcase
    endfunction

    function automatic int ndig(input int d);
        return (d == 2) ? 3 : 2;
    endfunction

    function automatic logic [11:0] to_bcd(input int v);
        logic [11:0] r;
        r[3:0]  = 4'(v % 10);
        r[7:4]  = 4'((v / 10) % 10);
        r[11:8] = 4'((v / 100) % 10);
        return r;
    endfunction

    function automatic stim_t mk(input logic clr, input logic ld, input logic tk,
                                 input logic up, input logic [11:0] sv);
        stim_t s;
        s.clr = clr; s.ld = ld; s.tk = tk; s.up = up; s.sv = sv;
        return s;
    endfunction

    // Drive one cycle of stimulus and push the model's expectation for each instance.
    task automatic apply(input stim_t s);
        exp_t x;
        int   v, dig;
        bit   ok;
        clear       = s.clr;
        load_enable = s.ld;
        clk_time    = s.tk;
        up_down     = s.up;
        sv12        = s.sv;
        for (int d = 0; d < 3; d++) begin
            x.c = 1'b0; x.b = 1'b0; x.e = 1'b0;
            if (s.clr) begin
                mval[d] = 0;
            end else if (s.ld) begin
                ok = 1'b1;
                v  = 0;
                for (int i = 0; i < ndig(d); i++) begin
                    dig = int'(s.sv[4*i +: 4]);
                    if (dig > 9) ok = 1'b0;
                    v += dig * (10 ** i);
                end
                if (ok && v <= maxv(d)) mval[d] = v;
                else                    x.e = 1'b1;
            end else if (s.tk) begin
                if (s.up) begin
                    if (mval[d] == maxv(d)) begin mval[d] = 0; x.c = 1'b1; end
                    else mval[d] = mval[d] + 1;
                end else begin
                    if (mval[d] == 0) begin mval[d] = maxv(d); x.b = 1'b1; end
                    else mval[d] = mval[d] - 1;
                end
            end
            x.val = to_bcd(mval[d]);
            sb.push_back(x);
        end
    endtask

    task automatic idle_inputs();
        clear = 1'b0; load_enable = 1'b0; clk_time = 1'b0; up_down = 1'b1; sv12 = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_p = 1'b1;
        @(negedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if ({got_val[d], got_c[d], got_b[d], got_e[d]} !== 15'h0) begin
                errors++;
                $display("FAIL reset dut%0d: got val=%h c=%b b=%b e=%b, need all 0",
                         d, got_val[d], got_c[d], got_b[d], got_e[d]);
            end
        end
        reset_p = 1'b0;
        for (int d = 0; d < 3; d++) mval[d] = 0;
        sb.delete();
    endtask

    task automatic test_up_count();
        stim_t s [$];
        exp_t  x;
        s.push_back(mk(0, 0, 0, 1, 12'h000));
        for (int i = 0; i < 60; i++) s.push_back(mk(0, 0, 1, 1, 12'h000));
        s.push_back(mk(0, 0, 0, 1, 12'h000));
        for (int k = 0; k < s.size(); k++) begin
            apply(s[k]);
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                x = sb.pop_front();
                checks++;
                if ({got_val[d], got_c[d], got_b[d], got_e[d]} !== {x.val, x.c, x.b, x.e}) begin
                    errors++;
                    $display("FAIL up_count step %0d dut%0d: got val=%h c=%b b=%b e=%b, need val=%h c=%b b=%b e=%b",
                             k, d, got_val[d], got_c[d], got_b[d], got_e[d], x.val, x.c, x.b, x.e);
                end
            end
        end
    endtask

    task automatic test_down_count();
        stim_t s [$];
        exp_t  x;
        s.push_back(mk(0, 0, 1, 0, 12'h000));
        s.push_back(mk(0, 0, 1, 0, 12'h000));
        s.push_back(mk(0, 0, 0, 0, 12'h000));
        for (int k = 0; k < s.size(); k++) begin
            apply(s[k]);
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                x = sb.pop_front();
                checks++;
                if ({got_val[d], got_c[d], got_b[d], got_e[d]} !== {x.val, x.c, x.b, x.e}) begin
                    errors++;
                    $display("FAIL down_count step %0d dut%0d: got val=%h c=%b b=%b e=%b, need val=%h c=%b b=%b e=%b",
                             k, d, got_val[d], got_c[d], got_b[d], got_e[d], x.val, x.c, x.b, x.e);
                end
            end
        end
    endtask

    task automatic test_loads();
        stim_t s [$];
        exp_t  x;
        s.push_back(mk(0, 1, 0, 1, 12'h045));
        s.push_back(mk(0, 1, 0, 1, 12'h060));
        s.push_back(mk(0, 0, 0, 1, 12'h000));
        s.push_back(mk(0, 1, 0, 1, 12'h03A));
        s.push_back(mk(0, 1, 0, 1, 12'h0A0));
        s.push_back(mk(0, 1, 1, 1, 12'h9F9));
        s.push_back(mk(0, 0, 0, 1, 12'h000));
        s.push_back(mk(0, 1, 1, 0, 12'h000));
        s.push_back(mk(0, 1, 0, 0, 12'h023));
        for (int k = 0; k < s.size(); k++) begin
            apply(s[k]);
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                x = sb.pop_front();
                checks++;
                if ({got_val[d], got_c[d], got_b[d], got_e[d]} !== {x.val, x.c, x.b, x.e}) begin
                    errors++;
                    $display("FAIL loads step %0d dut%0d: got val=%h c=%b b=%b e=%b, need val=%h c=%b b=%b e=%b",
                             k, d, got_val[d], got_c[d], got_b[d], got_e[d], x.val, x.c, x.b, x.e);
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        stim_t s [$];
        exp_t  x;
        s.push_back(mk(0, 1, 0, 1, 12'h059));
        s.push_back(mk(1, 1, 1, 1, 12'h045));
        s.push_back(mk(0, 1, 1, 1, 12'h059));
        s.push_back(mk(0, 0, 0, 1, 12'h000));
        s.push_back(mk(1, 0, 1, 0, 12'h000));
        s.push_back(mk(1, 1, 0, 0, 12'h0FF));
        for (int k = 0; k < s.size(); k++) begin
            apply(s[k]);
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                x = sb.pop_front();
                checks++;
                if ({got_val[d], got_c[d], got_b[d], got_e[d]} !== {x.val, x.c, x.b, x.e}) begin
                    errors++;
                    $display("FAIL simultaneous step %0d dut%0d: got val=%h c=%b b=%b e=%b, need val=%h c=%b b=%b e=%b",
                             k, d, got_val[d], got_c[d], got_b[d], got_e[d], x.val, x.c, x.b, x.e);
                end
            end
        end
    endtask

    task automatic test_ripple();
        stim_t s [$];
        exp_t  x;
        s.push_back(mk(0, 1, 0, 1, 12'h019));
        s.push_back(mk(0, 0, 1, 1, 12'h000));
        s.push_back(mk(0, 0, 1, 0, 12'h000));
        s.push_back(mk(0, 1, 0, 1, 12'h023));
        s.push_back(mk(0, 0, 1, 1, 12'h000));
        s.push_back(mk(0, 1, 0, 1, 12'h099));
        s.push_back(mk(0, 0, 1, 1, 12'h000));
        s.push_back(mk(0, 0, 1, 0, 12'h000));
        s.push_back(mk(0, 1, 0, 1, 12'h999));
        s.push_back(mk(0, 0, 1, 1, 12'h000));
        s.push_back(mk(0, 0, 1, 0, 12'h000));
        for (int k = 0; k < s.size(); k++) begin
            apply(s[k]);
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                x = sb.pop_front();
                checks++;
                if ({got_val[d], got_c[d], got_b[d], got_e[d]} !== {x.val, x.c, x.b, x.e}) begin
                    errors++;
                    $display("FAIL ripple step %0d dut%0d: got val=%h c=%b b=%b e=%b, need val=%h c=%b b=%b e=%b",
                             k, d, got_val[d], got_c[d], got_b[d], got_e[d], x.val, x.c, x.b, x.e);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        stim_t s [$];
        exp_t  x;
        s.push_back(mk(0, 1, 0, 1, 12'h059));
        s.push_back(mk(0, 0, 1, 1, 12'h000));
        s.push_back(mk(0, 0, 1, 0, 12'h000));
        s.push_back(mk(0, 0, 1, 1, 12'h000));
        s.push_back(mk(0, 0, 1, 0, 12'h000));
        s.push_back(mk(0, 1, 0, 1, 12'h0AA));
        s.push_back(mk(0, 1, 0, 1, 12'h077));
        s.push_back(mk(0, 0, 0, 1, 12'h000));
        for (int k = 0; k < s.size(); k++) begin
            apply(s[k]);
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                x = sb.pop_front();
                checks++;
                if ({got_val[d], got_c[d], got_b[d], got_e[d]} !== {x.val, x.c, x.b, x.e}) begin
                    errors++;
                    $display("FAIL back_to_back step %0d dut%0d: got val=%h c=%b b=%b e=%b, need val=%h c=%b b=%b e=%b",
                             k, d, got_val[d], got_c[d], got_b[d], got_e[d], x.val, x.c, x.b, x.e);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        stim_t s [$];
        exp_t  x;
        // Leaves instance 0 at 37 while instance 1 is showing its carry pulse.
        s.push_back(mk(0, 1, 0, 1, 12'h023));
        s.push_back(mk(0, 1, 0, 1, 12'h036));
        s.push_back(mk(0, 0, 1, 1, 12'h000));
        for (int k = 0; k < s.size(); k++) begin
            apply(s[k]);
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                x = sb.pop_front();
                checks++;
                if ({got_val[d], got_c[d], got_b[d], got_e[d]} !== {x.val, x.c, x.b, x.e}) begin
                    errors++;
                    $display("FAIL async_reset setup %0d dut%0d: got val=%h c=%b b=%b e=%b, need val=%h c=%b b=%b e=%b",
                             k, d, got_val[d], got_c[d], got_b[d], got_e[d], x.val, x.c, x.b, x.e);
                end
            end
        end
        idle_inputs();
        #2 reset_p = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if ({got_val[d], got_c[d], got_b[d], got_e[d]} !== 15'h0) begin
                errors++;
                $display("FAIL async_reset immediate dut%0d: got val=%h c=%b b=%b e=%b, need all 0",
                         d, got_val[d], got_c[d], got_b[d], got_e[d]);
            end
        end
        for (int d = 0; d < 3; d++) mval[d] = 0;
        sb.delete();
        @(negedge clk);
        reset_p = 1'b0;
        s.delete();
        s.push_back(mk(0, 0, 1, 1, 12'h000));
        s.push_back(mk(0, 0, 0, 1, 12'h000));
        for (int k = 0; k < s.size(); k++) begin
            apply(s[k]);
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                x = sb.pop_front();
                checks++;
                if ({got_val[d], got_c[d], got_b[d], got_e[d]} !== {x.val, x.c, x.b, x.e}) begin
                    errors++;
                    $display("FAIL async_reset resume %0d dut%0d: got val=%h c=%b b=%b e=%b, need val=%h c=%b b=%b e=%b",
                             k, d, got_val[d], got_c[d], got_b[d], got_e[d], x.val, x.c, x.b, x.e);
                end
            end
        end
    endtask

    initial begin
        reset_p = 1'b1;
        idle_inputs();
        test_reset();
        test_up_count();
        test_down_count();
        test_loads();
        test_simultaneous();
        test_ripple();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
